// File: rtl/lcd_text_functions_pkg.sv
// Character helpers shared by the LCD and UART text paths.
// Maps a 4-bit digit value to its uppercase ASCII hex character.
package lcd_text_functions_pkg;

   function automatic logic [7:0] ascii_of_hdigit(input logic [3:0] digit);
      return (digit < 4'd10) ? 8'h30 + {4'h0, digit} : 8'h37 + {4'h0, digit};
   endfunction

endpackage

// File: rtl/sf_ascii_fmt_pkg.sv
// Shared types and helpers for the binary-to-ASCII field formatters.
// Holds the converter FSM states, ASCII constants and the double-dabble digit correction.
package sf_ascii_fmt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_FORMAT
   } t_bcd_conv_state;

   localparam logic [7:0] C_ASCII_SPACE = 8'h20;
   localparam logic [7:0] C_ASCII_ZERO  = 8'h30;
   localparam logic [7:0] C_ASCII_STAR  = 8'h2A;

   // Pre-shift correction so a BCD digit of 5..9 carries correctly when doubled.
   function automatic logic [3:0] bcd_add3_adjust(input logic [3:0] digit);
      return (digit >= 4'd5) ? digit + 4'd3 : digit;
   endfunction

endpackage

// File: rtl/sf_errcnt_bcd_ascii.sv
// Sequential binary count to right-justified ASCII decimal/hex field converter.
// Decimal uses one double-dabble shift per clock; hex formats straight from the captured value.
module sf_errcnt_bcd_ascii
   import sf_ascii_fmt_pkg::*;
   import lcd_text_functions_pkg::*;
#(
   parameter int parm_bin_width = 32,
   parameter int parm_digits    = 8
) (
   input  logic                        i_clk_40mhz,
   input  logic                        i_rst_40mhz,
   input  logic                        i_start,
   input  logic [parm_bin_width-1:0]   i_value,
   input  logic                        i_hex_mode,
   input  logic                        i_blank_lead,
   output logic                        o_busy,
   output logic                        o_done,
   output logic [parm_digits*8-1:0]    o_ascii,
   output logic                        o_overflow
);

   localparam int BCD_W = 4 * parm_digits;
   localparam int EXT_W = (parm_bin_width > BCD_W) ? parm_bin_width : BCD_W;
   localparam int CNT_W = $clog2(parm_bin_width + 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(parm_bin_width - 1);
   localparam logic [EXT_W-1:0] LOW_MASK   = EXT_W'({BCD_W{1'b1}});

   t_bcd_conv_state             state_q, state_d;
   logic [parm_bin_width-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]            bcd_q, bcd_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        hex_q, hex_d;
   logic                        blank_q, blank_d;
   logic                        ovf_q, ovf_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [parm_digits*8-1:0]    ascii_q, ascii_d;
   logic                        overflow_q, overflow_d;

   logic [BCD_W-1:0]            bcd_adj;
   logic [EXT_W-1:0]            val_ext;
   logic                        fmt_ovf;
   logic [parm_digits*8-1:0]    fmt_text;
   logic [3:0]                  digit;
   logic                        leading;

   for (genvar g = 0; g < parm_digits; g++) begin : g_adj
      assign bcd_adj[4*g +: 4] = bcd_add3_adjust(bcd_q[4*g +: 4]);
   end

   // Text for the finished conversion; digits scanned from the most significant end.
   always_comb begin
      val_ext                      = '0;
      val_ext[parm_bin_width-1:0]  = bin_q;
      fmt_ovf  = hex_q ? |(val_ext & ~LOW_MASK) : ovf_q;
      fmt_text = '0;
      digit    = '0;
      leading  = blank_q;
      for (int i = parm_digits - 1; i >= 0; i--) begin
         digit = hex_q ? val_ext[4*i +: 4] : bcd_q[4*i +: 4];
         if (digit != 4'd0 || i == 0) leading = 1'b0;
         fmt_text[8*i +: 8] = leading ? C_ASCII_SPACE : ascii_of_hdigit(digit);
         if (fmt_ovf) fmt_text[8*i +: 8] = C_ASCII_STAR;
      end
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      hex_d      = hex_q;
      blank_d    = blank_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ascii_d    = ascii_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: begin
            // Blocking on done_q makes the earliest re-accept the edge after the pulse ends.
            if (i_start && !done_q) begin
               bin_d   = i_value;
               hex_d   = i_hex_mode;
               blank_d = i_blank_lead;
               busy_d  = 1'b1;
               if (i_hex_mode) begin
                  state_d = ST_FORMAT;
               end else begin
                  bcd_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[parm_bin_width-1]};
            bin_d = bin_q << 1;
            ovf_d = ovf_q | bcd_adj[BCD_W-1];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_SHIFT) state_d = ST_FORMAT;
         end
         ST_FORMAT: begin
            ascii_d    = fmt_text;
            overflow_d = fmt_ovf;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: registers update with <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz) begin
      if (!i_rst_40mhz) begin
         state_q    <= ST_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         hex_q      <= 1'b0;
         blank_q    <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ascii_q    <= {parm_digits{C_ASCII_ZERO}};
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         hex_q      <= hex_d;
         blank_q    <= blank_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ascii_q    <= ascii_d;
         overflow_q <= overflow_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_ascii    = ascii_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_sf_errcnt_bcd_ascii.sv
// Self-checking bench for sf_errcnt_bcd_ascii: directed and random conversions on an
// 8-digit and a 4-digit instance, scored against an arithmetic text model.
module tb_sf_errcnt_bcd_ascii;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [W-1:0] value = '0;
   logic        hex = 1'b0, blank = 1'b0;

   logic        busy_a, done_a, ovf_a;
   logic [63:0] ascii_a;
   logic        busy_b, done_b, ovf_b;
   logic [31:0] ascii_b;

   int vectors = 0;
   int miscompares = 0;

   always #12 clk = ~clk;

   sf_errcnt_bcd_ascii #(.parm_bin_width(W), .parm_digits(8)) u_dut_a (
      .i_clk_40mhz (clk),
      .i_rst_40mhz (rst_n),
      .i_start     (start_a),
      .i_value     (value),
      .i_hex_mode  (hex),
      .i_blank_lead(blank),
      .o_busy      (busy_a),
      .o_done      (done_a),
      .o_ascii     (ascii_a),
      .o_overflow  (ovf_a)
   );

   sf_errcnt_bcd_ascii #(.parm_bin_width(W), .parm_digits(4)) u_dut_b (
      .i_clk_40mhz (clk),
      .i_rst_40mhz (rst_n),
      .i_start     (start_b),
      .i_value     (value),
      .i_hex_mode  (hex),
      .i_blank_lead(blank),
      .o_busy      (busy_b),
      .o_done      (done_b),
      .o_ascii     (ascii_b),
      .o_overflow  (ovf_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Right-justified text of v in nd characters, built by repeated division.
   function automatic logic [63:0] model_text(input longint unsigned v, input bit hx,
                                               input bit bl, input int nd, output bit ovf);
      longint unsigned base = hx ? 64'd16 : 64'd10;
      longint unsigned lim  = 1;
      longint unsigned rem  = v;
      int              d[8];
      logic [63:0]     t    = '0;
      bit              lead = bl;
      for (int i = 0; i < nd; i++) lim = lim * base;
      ovf = (v >= lim);
      for (int i = 0; i < nd; i++) begin
         d[i] = int'(rem % base);
         rem  = rem / base;
      end
      for (int i = nd - 1; i >= 0; i--) begin
         if (ovf)                              t[8*i +: 8] = 8'h2A;
         else if (lead && d[i] == 0 && i != 0) t[8*i +: 8] = 8'h20;
         else begin
            lead = 1'b0;
            t[8*i +: 8] = (d[i] < 10) ? 8'(48 + d[i]) : 8'(55 + d[i]);
         end
      end
      return t;
   endfunction

   task automatic conv(input bit sel, input logic [W-1:0] v, input bit hx, input bit bl,
                       input string tag);
      int          nd = sel ? 4 : 8;
      int          lat = hx ? 1 : W + 1;
      logic [63:0] exp_txt;
      logic [63:0] got_txt;
      bit          exp_ovf;
      int          n = 0;
      int          busy_cnt = 0;
      exp_txt = model_text(64'(v), hx, bl, nd, exp_ovf);
      @(posedge clk); #1;
      value = v; hex = hx; blank = bl;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      value = $urandom; hex = 1'($urandom); blank = 1'($urandom);
      if (sel ? busy_b : busy_a) busy_cnt++;
      while (!(sel ? done_b : done_a) && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (sel ? busy_b : busy_a) busy_cnt++;
      end
      got_txt = sel ? 64'(ascii_b) : ascii_a;
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " busy"}, 64'(busy_cnt), 64'(lat));
      check({tag, " text"}, got_txt, exp_txt);
      check({tag, " ovf"}, 64'(sel ? ovf_b : ovf_a), 64'(exp_ovf));
      @(posedge clk); #1;
      check({tag, " done1"}, 64'(sel ? done_b : done_a), 64'd0);
      check({tag, " hold"}, sel ? 64'(ascii_b) : ascii_a, exp_txt);
   endtask

   initial begin
      bit          dummy;
      int          dcount;
      int          first_n, second_n;
      logic [63:0] first_t, second_t;
      bit          seen;

      #5 rst_n = 1'b0;
      #20;
      check("rst text_a", ascii_a, 64'h3030303030303030);
      check("rst text_b", 64'(ascii_b), 64'h30303030);
      check("rst busy", 64'({busy_a, busy_b}), 64'd0);
      check("rst done", 64'({done_a, done_b}), 64'd0);
      check("rst ovf", 64'({ovf_a, ovf_b}), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      conv(0, 32'd12345,     0, 1, "dec12345");
      conv(0, 32'd0,         0, 1, "dec0b");
      conv(0, 32'd0,         0, 0, "dec0");
      conv(0, 32'd99999999,  0, 1, "dec_max");
      conv(0, 32'd100000000, 0, 1, "dec_ovf");
      conv(0, 32'd7,         0, 0, "dec7");
      conv(0, 32'hDEADBEEF,  1, 1, "hexbeef");
      conv(0, 32'h00000ABC,  1, 1, "hexabc");
      conv(0, 32'hFFFFFFFF,  0, 0, "dec_full");
      conv(1, 32'h00010000,  1, 0, "b_hexovf");
      conv(1, 32'h0000BEEF,  1, 1, "b_hex");
      conv(1, 32'd9999,      0, 1, "b_dec_max");
      conv(1, 32'd10000,     0, 0, "b_dec_ovf");
      conv(1, 32'd0,         1, 1, "b_hex0");

      // Start held high: one result per accept, re-accept only after done drops.
      @(posedge clk); #1;
      value = 32'd42; hex = 1'b0; blank = 1'b1; start_a = 1'b1;
      @(posedge clk); #1;
      dcount = 0; first_n = 0; second_n = 0; first_t = '0; second_t = '0;
      for (int n = 1; n <= 69; n++) begin
         @(posedge clk); #1;
         if (n == 10) value = 32'd77;
         if (done_a) begin
            dcount++;
            if (dcount == 1) begin first_n = n; first_t = ascii_a; end
            if (dcount == 2) begin second_n = n; second_t = ascii_a; end
         end
      end
      start_a = 1'b0;
      check("held count", 64'(dcount), 64'd2);
      check("held first_at", 64'(first_n), 64'd33);
      check("held first_txt", first_t, model_text(64'd42, 1'b0, 1'b1, 8, dummy));
      check("held second_at", 64'(second_n), 64'd68);
      check("held second_txt", second_t, model_text(64'd77, 1'b0, 1'b1, 8, dummy));
      @(posedge clk); #1;
      check("held idle", 64'(busy_a), 64'd0);

      // Reset in the middle of the shift phase.
      value = 32'd500; hex = 1'b0; blank = 1'b1; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort busy", 64'(busy_a), 64'd0);
      check("abort text", ascii_a, 64'h3030303030303030);
      check("abort ovf", 64'(ovf_a), 64'd0);
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done_a) seen = 1'b1;
         if (n == 5) rst_n = 1'b1;
      end
      check("abort nodone", 64'(seen), 64'd0);
      conv(0, 32'd9, 0, 1, "after_rst");

      // Random conversions across both instances.
      for (int it = 0; it < 40; it++) begin
         bit              sel = ($urandom_range(0, 3) == 0);
         bit              hx  = 1'($urandom);
         bit              bl  = 1'($urandom);
         int              nd  = sel ? 4 : 8;
         longint unsigned lim = 1;
         longint unsigned v;
         for (int i = 0; i < nd; i++) lim = lim * (hx ? 64'd16 : 64'd10);
         case ($urandom_range(0, 3))
            0: v = 64'($urandom_range(0, 999));
            1: v = lim - 64'd5 + 64'($urandom_range(0, 10));
            2: v = 64'($urandom);
            default: v = 64'($urandom) % lim;
         endcase
         if (v > 64'hFFFFFFFF) v = 64'hFFFFFFFF;
         conv(sel, W'(v), hx, bl, $sformatf("rnd%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
